volume_step_sequencer: RTL and testbench
========================================

// Module: volume_step_sequencer
// PURPOSE
//  Sequences the volume counter: turns user and system requests into single-cycle increase/decrease
//  pulses, at most one step per tick. Requests are button holds (with auto-repeat), preset-level
//  requests (ramped) and mute/unmute (ramped). Keeps a shadow of the counter's 0..MAX_LEVEL value.
//  Sits between the debounced buttons/control logic and the volume counter; its pulse outputs drive
//  the counter's increase/decrease inputs directly.
// PARAMETERS
//  LEVEL_W       4    width of level values
//  MAX_LEVEL     15   top level; must match the counter's saturation value
//  REPEAT_DELAY  50   ticks a button is held before auto-repeat starts
//  REPEAT_RATE   10   ticks between auto-repeat steps
//  RAMP_DIV      2    ticks between steps while ramping (preset/mute/unmute)
// PORTS
//  clk              in   1        global clock
//  rst              in   1        synchronous reset, active-high
//  tick             in   1        1-cycle step-rate enable (e.g. 100 Hz)
//  btn_up           in   1        debounced level, volume-up held
//  btn_dn           in   1        debounced level, volume-down held
//  mute_toggle      in   1        1-cycle pulse, toggles mute
//  preset_valid     in   1        preset request valid
//  preset_level     in   LEVEL_W  requested level; values >MAX_LEVEL are clamped to MAX_LEVEL
//  preset_ready     out  1        preset accepted when valid&&ready
//  increase_volumn  out  1        1-cycle step-up pulse to the counter
//  decrease_volumn  out  1        1-cycle step-down pulse to the counter
//  cur_level        out  LEVEL_W  shadow level
//  muted            out  1        mute state
//  busy             out  1        state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; cur_level=0; muted=0; saved_level=0; pulses=0; busy=0;
//    preset_ready=1; tick counters=0.
//  - Pulses are registered. cur_level changes on the same clock edge that raises a pulse, so the
//    counter's value matches cur_level one cycle later. Inc and dec are never high together.
//  - No pulse is issued past a bound: no inc at MAX_LEVEL, no dec at 0. A blocked step is
//    dropped silently.
//  - FSM states: IDLE, HOLD_UP, HOLD_DN, RAMP. Evaluation priority in every state:
//    buttons > mute_toggle > preset.
//  - btn_up and btn_dn both high: treated as neither.
//  - IDLE -> HOLD_UP on a rising edge of btn_up (btn_dn alone: HOLD_DN, mirrored).
//    Step immediately on the next tick, then once REPEAT_DELAY ticks have elapsed since that
//    first step, then every REPEAT_RATE ticks. Button release -> IDLE.
//  - Any button edge clears muted. The step starts from the current cur_level.
//  - mute_toggle with muted=0: saved_level<=cur_level; target<=0; muted<=1; ->RAMP.
//  - mute_toggle with muted=1: target<=saved_level; muted<=0; ->RAMP.
//  - Preset: preset_ready = (state is IDLE or RAMP) && !btn_up && !btn_dn.
//    On accept: target<=clamp(preset_level); muted<=0; ->RAMP.
//    A new accept or mute_toggle during RAMP retargets, and the divider continues.
//  - RAMP: one step toward target every RAMP_DIV ticks, first step on the first tick after entry.
//    cur_level==target -> IDLE, with no pulse.
//  - A button edge during RAMP aborts the ramp -> HOLD_*.
//  - A mute_toggle and a preset_valid in the same cycle: mute wins, preset not accepted.
//  - rst mid-operation: returns to reset values next edge. The counter must be reset by the same rst
//    to stay aligned.
// TESTING
//  1. Reset, then btn_up held 3 ticks with REPEAT_DELAY=4 -> exactly 1 inc pulse, cur_level=1.
//  2. Hold btn_up 200 ticks (defaults) -> steps saturate; cur_level=15; no inc while cur_level=15.
//  3. cur_level=3, preset 12 accepted, RAMP_DIV=2 -> 9 inc pulses 2 ticks apart, then IDLE, busy=0.
//  4. cur_level=10, mute_toggle -> 10 dec pulses, muted=1, cur_level=0.
//     Second mute_toggle -> 10 inc pulses back to 10, muted=0.
//  5. Ramp to 12 in progress at level 6, then btn_dn edge -> ramp aborted, 1 dec on next tick,
//     cur_level=5; preset_ready=0 while held.
//  6. btn_up&&btn_dn together -> no pulses; preset_level=15 at 15 -> RAMP then IDLE, no pulse;
//     rst mid-ramp -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/volume_step_sequencer_if.sv
// Preset request handshake for the volume step sequencer.
// master drives valid/level, slave returns ready.
interface volume_step_sequencer_if #(
  parameter int LEVEL_W = 4
);
  logic               valid;
  logic [LEVEL_W-1:0] level;
  logic               ready;

  modport master (
    output valid,
    output level,
    input  ready
  );

  modport slave (
    input  valid,
    input  level,
    output ready
  );
endinterface

// File: rtl/volume_step_sequencer.sv
// Turns button holds, preset requests and mute toggles into 1-cycle
// inc/dec pulses for the volume counter, at most one step per tick.
// Ports: clk, rst (sync, active-high), tick, btn_up, btn_dn,
//   mute_toggle, preset (slave handshake), increase_volumn,
//   decrease_volumn, cur_level (shadow), muted, busy.
module volume_step_sequencer #(
  parameter int LEVEL_W      = 4,
  parameter int MAX_LEVEL    = 15,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int RAMP_DIV     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                btn_up,
  input  logic                btn_dn,
  input  logic                mute_toggle,
  volume_step_sequencer_if.slave preset,
  output logic                increase_volumn,
  output logic                decrease_volumn,
  output logic [LEVEL_W-1:0]  cur_level,
  output logic                muted,
  output logic                busy
);

  localparam int HMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(HMAX + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam logic [LEVEL_W-1:0] LMAX = LEVEL_W'(MAX_LEVEL);

  typedef enum logic [1:0] {
    IDLE, HOLD_UP, HOLD_DN, RAMP
  } state_t;

  state_t state, state_n;

  logic               up_q, dn_q;
  logic               hold_first, hold_rep;
  logic [CW-1:0]      hold_cnt;
  logic [RW-1:0]      ramp_cnt;
  logic [LEVEL_W-1:0] target, saved_level;

  // Both buttons high counts as neither pressed.
  logic up_eff, dn_eff, up_rise, dn_rise;
  assign up_eff  = btn_up & ~btn_dn;
  assign dn_eff  = btn_dn & ~btn_up;
  assign up_rise = up_eff & ~up_q;
  assign dn_rise = dn_eff & ~dn_q;

  logic held, accept, ramp_hit, in_hold;
  assign in_hold  = (state == HOLD_UP) || (state == HOLD_DN);
  assign held     = ((state == HOLD_UP) && up_eff) ||
                    ((state == HOLD_DN) && dn_eff);
  assign accept   = preset.valid && preset.ready && !mute_toggle;
  assign ramp_hit = (cur_level == target);

  logic [CW-1:0] hold_nxt;
  assign hold_nxt = hold_cnt + CW'(1);

  logic [LEVEL_W-1:0] clamp_lvl;
  assign clamp_lvl =
    ({1'b0, preset.level} > (LEVEL_W + 1)'(MAX_LEVEL)) ?
    LMAX : preset.level;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (up_rise)          state_n = HOLD_UP;
    else if (dn_rise)     state_n = HOLD_DN;
    else if (held)        state_n = state;
    else if (mute_toggle) state_n = RAMP;
    else if (accept)      state_n = RAMP;
    else if (in_hold)     state_n = IDLE;
    else if (state == RAMP && ramp_hit)
      state_n = IDLE;
  end

  logic hold_fire, ramp_fire, go_up, go_dn;
  logic inc_d, dec_d;

  always_comb begin
    hold_fire = tick && held &&
      (hold_first ||
       (!hold_rep && hold_nxt == CW'(REPEAT_DELAY)) ||
       ( hold_rep && hold_nxt == CW'(REPEAT_RATE)));
    ramp_fire = tick && (state == RAMP) &&
      (state_n == RAMP) && (ramp_cnt == '0) &&
      !ramp_hit && !mute_toggle && !accept;
    go_up = (hold_fire && state == HOLD_UP) ||
            (ramp_fire && target > cur_level);
    go_dn = (hold_fire && state == HOLD_DN) ||
            (ramp_fire && target < cur_level);
    inc_d = go_up && (cur_level != LMAX);
    dec_d = go_dn && (cur_level != '0);
    busy  = (state != IDLE);
    preset.ready = ((state == IDLE) || (state == RAMP)) &&
                   !btn_up && !btn_dn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q            <= 1'b0;
      dn_q            <= 1'b0;
      increase_volumn <= 1'b0;
      decrease_volumn <= 1'b0;
      cur_level       <= '0;
      muted           <= 1'b0;
      target          <= '0;
      saved_level     <= '0;
      hold_first      <= 1'b0;
      hold_rep        <= 1'b0;
      hold_cnt        <= '0;
      ramp_cnt        <= '0;
    end else begin
      up_q            <= up_eff;
      dn_q            <= dn_eff;
      increase_volumn <= inc_d;
      decrease_volumn <= dec_d;
      if (inc_d)      cur_level <= cur_level + LEVEL_W'(1);
      else if (dec_d) cur_level <= cur_level - LEVEL_W'(1);

      if (up_rise || dn_rise) begin
        muted      <= 1'b0;
        hold_first <= 1'b1;
        hold_rep   <= 1'b0;
        hold_cnt   <= '0;
      end else if (held) begin
        if (tick) begin
          if (hold_first) begin
            hold_first <= 1'b0;
            hold_cnt   <= '0;
          end else if (hold_fire) begin
            hold_rep <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_nxt;
          end
        end
      end else if (mute_toggle) begin
        if (muted) begin
          target <= saved_level;
          muted  <= 1'b0;
        end else begin
          saved_level <= cur_level;
          target      <= '0;
          muted       <= 1'b1;
        end
      end else if (accept) begin
        target <= clamp_lvl;
        muted  <= 1'b0;
      end

      // Retargeting inside RAMP keeps the divider phase.
      if (state_n == RAMP && state != RAMP)
        ramp_cnt <= '0;
      else if (state == RAMP && tick)
        ramp_cnt <= (ramp_cnt == RW'(RAMP_DIV - 1)) ?
                    '0 : ramp_cnt + RW'(1);
    end
  end

endmodule

// File: tb/tb_volume_step_sequencer.sv
// Directed bench for volume_step_sequencer with a pulse scoreboard.
// Expected pulses are queued when stimulus is driven.
module tb_volume_step_sequencer;

  logic clk = 1'b0;
  logic rst, tick, btn_up, btn_dn, mute_toggle;
  always #5 clk = ~clk;

  volume_step_sequencer_if #(.LEVEL_W(4)) pi ();
  volume_step_sequencer_if #(.LEVEL_W(4)) pia ();
  assign pia.valid = pi.valid;
  assign pia.level = pi.level;

  logic       inc, dec, muted, busy;
  logic [3:0] lvl;
  logic       inc_a, dec_a, muted_a, busy_a;
  logic [3:0] lvl_a;

  volume_step_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_up(btn_up), .btn_dn(btn_dn),
    .mute_toggle(mute_toggle), .preset(pi.slave),
    .increase_volumn(inc), .decrease_volumn(dec),
    .cur_level(lvl), .muted(muted), .busy(busy)
  );

  volume_step_sequencer #(.REPEAT_DELAY(4)) dut_a (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_up(btn_up), .btn_dn(btn_dn),
    .mute_toggle(mute_toggle), .preset(pia.slave),
    .increase_volumn(inc_a), .decrease_volumn(dec_a),
    .cur_level(lvl_a), .muted(muted_a), .busy(busy_a)
  );

  typedef struct packed {
    logic       up;
    logic       dn;
    logic [3:0] lv;
    int         tk;
  } ev_t;

  ev_t q[$];
  ev_t got;
  int  errors = 0;
  int  checks = 0;
  int  tick_no = 0;
  int  cnt_a = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (inc || dec) begin
      got = '{inc, dec, lvl, tick_no};
      chk("inc_dec_excl", 64'(inc & dec), 64'd0);
      if (q.size() == 0) chk("unexpected_pulse", 64'(got), 64'd0);
      else               chk("pulse", 64'(got), 64'(q.pop_front()));
    end
  end

  always @(negedge clk) if (inc_a) cnt_a++;

  task automatic tk();
    @(negedge clk);
    tick = 1'b1;
    tick_no++;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preset(int l);
    @(negedge clk);
    pi.valid = 1'b1;
    pi.level = 4'(l);
    #1 chk("preset_ready", 64'(pi.ready), 64'd1);
    @(negedge clk);
    pi.valid = 1'b0;
  endtask

  task automatic mute();
    @(negedge clk);
    mute_toggle = 1'b1;
    @(negedge clk);
    mute_toggle = 1'b0;
  endtask

  task automatic ramp_exp(bit up, int from, int n);
    int t0 = tick_no;
    for (int i = 0; i < n; i++)
      q.push_back('{up, !up,
        4'(up ? from + i + 1 : from - i - 1), t0 + 1 + 2 * i});
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_lvl"}, 64'(lvl), 64'd0);
    chk({tag, "_muted"}, 64'(muted), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(pi.ready), 64'd1);
    chk({tag, "_pulses"}, 64'({inc, dec}), 64'd0);
  endtask

  initial begin
    int t0;
    rst = 1'b1; tick = 1'b0; btn_up = 1'b0; btn_dn = 1'b0;
    mute_toggle = 1'b0; pi.valid = 1'b0; pi.level = 4'd0;
    cyc(3);
    chk_reset("reset");
    rst = 1'b0;
    cyc(1);

    // mute and preset together: mute wins
    @(negedge clk);
    mute_toggle = 1'b1; pi.valid = 1'b1; pi.level = 4'd5;
    @(negedge clk);
    mute_toggle = 1'b0; pi.valid = 1'b0;
    chk("mute_wins_muted", 64'(muted), 64'd1);
    cyc(1);
    chk("mute_at0_idle", 64'(busy), 64'd0);
    repeat (3) tk();
    mute();
    chk("unmute0", 64'(muted), 64'd0);
    cyc(2);

    // single step with short repeat delay, then long hold
    t0 = tick_no;
    q.push_back('{1'b1, 1'b0, 4'd1, t0 + 1});
    for (int k = 0; k < 14; k++)
      q.push_back('{1'b1, 1'b0, 4'(2 + k), t0 + 51 + 10 * k});
    @(negedge clk) btn_up = 1'b1;
    repeat (3) tk();
    chk("t1_cnt_a", 64'(cnt_a), 64'd1);
    chk("t1_lvl_a", 64'(lvl_a), 64'd1);
    chk("t1_lvl", 64'(lvl), 64'd1);
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_ready", 64'(pi.ready), 64'd0);
    repeat (197) tk();
    chk("t2_sat", 64'(lvl), 64'd15);
    @(negedge clk) btn_up = 1'b0;
    cyc(2);
    chk("t2_idle", 64'(busy), 64'd0);

    // preset ramps
    ramp_exp(1'b0, 15, 12); preset(3);
    repeat (23) tk(); cyc(1);
    chk("to3_lvl", 64'(lvl), 64'd3);
    ramp_exp(1'b1, 3, 9); preset(12);
    repeat (17) tk(); cyc(1);
    chk("t3_lvl", 64'(lvl), 64'd12);
    chk("t3_idle", 64'(busy), 64'd0);
    ramp_exp(1'b0, 12, 2); preset(10);
    repeat (3) tk(); cyc(1);

    // mute / unmute ramps
    ramp_exp(1'b0, 10, 10); mute();
    chk("t4_muted", 64'(muted), 64'd1);
    repeat (19) tk(); cyc(1);
    chk("t4_lvl0", 64'(lvl), 64'd0);
    chk("t4_idle", 64'(busy), 64'd0);
    ramp_exp(1'b1, 0, 10); mute();
    repeat (19) tk(); cyc(1);
    chk("t4_lvl10", 64'(lvl), 64'd10);
    chk("t4_unmuted", 64'(muted), 64'd0);

    // button edge aborts a ramp
    ramp_exp(1'b0, 10, 6); preset(4);
    repeat (11) tk(); cyc(1);
    ramp_exp(1'b1, 4, 2); preset(12);
    repeat (4) tk();
    chk("t5_lvl6", 64'(lvl), 64'd6);
    chk("t5_busy", 64'(busy), 64'd1);
    @(negedge clk) btn_dn = 1'b1;
    q.push_back('{1'b0, 1'b1, 4'd5, tick_no + 1});
    tk();
    chk("t5_lvl5", 64'(lvl), 64'd5);
    chk("t5_ready", 64'(pi.ready), 64'd0);
    @(negedge clk) btn_dn = 1'b0;
    cyc(2);
    chk("t5_idle", 64'(busy), 64'd0);

    // both buttons: no steps
    @(negedge clk);
    btn_up = 1'b1; btn_dn = 1'b1;
    repeat (5) tk();
    chk("both_idle", 64'(busy), 64'd0);
    chk("both_lvl", 64'(lvl), 64'd5);
    chk("both_ready", 64'(pi.ready), 64'd0);
    @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0;
    cyc(1);

    // preset equal to current level at top
    ramp_exp(1'b1, 5, 10); preset(15);
    repeat (19) tk(); cyc(1);
    chk("to15_lvl", 64'(lvl), 64'd15);
    preset(15);
    chk("same_busy", 64'(busy), 64'd1);
    cyc(1);
    chk("same_idle", 64'(busy), 64'd0);
    chk("same_lvl", 64'(lvl), 64'd15);

    // reset mid-ramp
    ramp_exp(1'b0, 15, 2); preset(0);
    repeat (4) tk();
    chk("mid_busy", 64'(busy), 64'd1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    cyc(2);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
